// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 write-cycle controller.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC,
        INIT_WAIT
    } lcd_state_t;

    localparam int LCD_ON_BIT   = 31;
    localparam int LCD_BLON_BIT = 30;
    localparam int LCD_REQ_BIT  = 10;
    localparam int LCD_RS_BIT   = 9;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int INIT_LEN = 6;
    // Function set 8-bit/2-line three times, display on, clear, entry mode.
    localparam logic [0:INIT_LEN-1][7:0] INIT_ROM = {8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
    endfunction

    function automatic int max_cyc(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter that sets the dwell of every controller state.
module lcd_delay_cnt #(
    parameter int              CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= RST_VAL;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    // A value of 1 means the current cycle is the last one of the dwell.
    assign done = (cnt_reg <= CNT_W'(1));

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-cycle sequencer driven by a toggle-handshake LCD word.
// Optional power-up init sequence is enabled by defining LCD_CTRL_INIT_EN.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_EXEC_CYC  = 2000,
    parameter int T_CLR_CYC   = 82000,
    parameter int T_PWR_CYC   = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_word,
    output logic        o_busy,
    output logic        o_ack_tgl,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon
);

    localparam int CNT_MAX = max_cyc(max_cyc(max_cyc(T_SETUP_CYC, T_EN_CYC),
                                             max_cyc(T_HOLD_CYC, T_EXEC_CYC)),
                                     max_cyc(T_CLR_CYC, T_PWR_CYC));
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    if (T_SETUP_CYC < 1 || T_EN_CYC < 1 || T_HOLD_CYC < 1 ||
        T_EXEC_CYC < 1 || T_CLR_CYC < 1 || T_PWR_CYC < 1) begin : g_bad_timing
        $error("lcd_ctrl: every T_*_CYC parameter must be at least 1");
    end

`ifdef LCD_CTRL_INIT_EN
    localparam lcd_state_t       RST_STATE = INIT_WAIT;
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(T_PWR_CYC);
`else
    localparam lcd_state_t       RST_STATE = IDLE;
    localparam logic [CNT_W-1:0] CNT_RST   = '0;
`endif

    lcd_state_t       state_reg, state_next;
    logic [7:0]       data_reg, data_next;
    logic             rs_reg, rs_next;
    logic             en_reg, en_next;
    logic             ack_reg, ack_next;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;
    logic             pending;

`ifdef LCD_CTRL_INIT_EN
    logic [2:0]       init_idx_reg, init_idx_next;
    logic             init_act_reg, init_act_next;
`endif

    logic unused_word_bits;
    assign unused_word_bits = ^{i_lcd_word[29:11], i_lcd_word[8]};

    lcd_delay_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_RST)
    ) u_delay (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    assign pending = i_lcd_word[LCD_REQ_BIT] ^ ack_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= RST_STATE;
            data_reg  <= '0;
            rs_reg    <= 1'b0;
            en_reg    <= 1'b0;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            rs_reg    <= rs_next;
            en_reg    <= en_next;
            ack_reg   <= ack_next;
        end
    end

`ifdef LCD_CTRL_INIT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            init_idx_reg <= '0;
            init_act_reg <= 1'b1;
        end else begin
            init_idx_reg <= init_idx_next;
            init_act_reg <= init_act_next;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        rs_next    = rs_reg;
        ack_next   = ack_reg;
        en_next    = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = CNT_W'(T_SETUP_CYC);
`ifdef LCD_CTRL_INIT_EN
        init_idx_next = init_idx_reg;
        init_act_next = init_act_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (pending) begin
                    data_next  = i_lcd_word[7:0];
                    rs_next    = i_lcd_word[LCD_RS_BIT];
                    ack_next   = i_lcd_word[LCD_REQ_BIT];
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(T_SETUP_CYC);
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(T_EN_CYC);
                    en_next    = 1'b1;
                    state_next = PULSE;
                end
            end
            PULSE: begin
                en_next = 1'b1;
                if (cnt_done) begin
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(T_HOLD_CYC);
                    en_next    = 1'b0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    cnt_load   = 1'b1;
                    cnt_val    = is_long_cmd(rs_reg, data_reg) ? CNT_W'(T_CLR_CYC)
                                                                : CNT_W'(T_EXEC_CYC);
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt_done) begin
                    state_next = IDLE;
`ifdef LCD_CTRL_INIT_EN
                    // Init commands chain straight into the next SETUP.
                    if (init_act_reg) begin
                        if (init_idx_reg == 3'(INIT_LEN - 1)) begin
                            init_act_next = 1'b0;
                        end else begin
                            init_idx_next = init_idx_reg + 3'd1;
                            data_next     = INIT_ROM[init_idx_reg + 3'd1];
                            rs_next       = 1'b0;
                            cnt_load      = 1'b1;
                            cnt_val       = CNT_W'(T_SETUP_CYC);
                            state_next    = SETUP;
                        end
                    end
`endif
                end
            end
            INIT_WAIT: begin
`ifdef LCD_CTRL_INIT_EN
                if (cnt_done) begin
                    data_next  = INIT_ROM[0];
                    rs_next    = 1'b0;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(T_SETUP_CYC);
                    state_next = SETUP;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_busy     = (state_reg != IDLE) | pending;
    assign o_ack_tgl  = ack_reg;
    assign o_lcd_data = data_reg;
    assign o_lcd_rs   = rs_reg;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_reg;
    assign o_lcd_on   = i_lcd_word[LCD_ON_BIT];
    assign o_lcd_blon = i_lcd_word[LCD_BLON_BIT];

endmodule
